instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle control FSM that sequences the instruction datapath: fetches an instruction over a valid/request handshake, holds it in the instruction register feeding immediate generation and decode, then steps through decode, execute, memory and write-back, issuing per-cycle enables for PC, register file, ALU operand muxes and data memory. Sits between instruction/data memories and the decode/execute datapath; it is the only block allowed to write the PC or register file.

## Interface
- TIMEOUT, 16: max cycles a memory request may stay unanswered before FAULT (≥2)
- clk  in  1  clock, all state on rising edge
- rstn  in  1  synchronous, active-low reset
- imemReq  out  1  instruction fetch request
- imemValid  in  1  instruction data valid (sampled only while imemReq=1)
- imemData  in  32  fetched instruction
- instr  out  32  instruction register to decode/immediate logic
- brTaken  in  1  branch compare result from ALU, valid in EXEC
- dmemReq  out  1  data memory request
- dmemWe  out  1  1 = store, 0 = load (meaningful while dmemReq=1)
- dmemValid  in  1  data access complete (sampled only while dmemReq=1)
- pcWrite  out  1  PC load enable
- pcSel  out  2  0 = pc+4, 1 = pc+imm (branch/JAL), 2 = (rs1+imm)&~1 (JALR)
- regWrite  out  1  register file write enable
- wbSel  out  2  0 = ALU, 1 = load data, 2 = pc+4
- aluSrcA  out  1  0 = rs1, 1 = pc (AUIPC, JAL)
- aluSrcB  out  1  0 = rs2, 1 = imm
- state  out  3  current state encoding (debug)
- fault  out  1  sticky fault flag

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5; other encodings go to FAULT.
- Classes by instr[6:0]: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 0001111 FENCE (no-op); anything else illegal.
- FETCH: imemReq=1. imemValid=1 → instr<=imemData, go DECODE. Else wait counter increments.
- DECODE: single cycle; illegal class → FAULT, else EXEC.
- EXEC: aluSrcA/aluSrcB driven per class (B: R/BRANCH=0, else 1; A: AUIPC/JAL=1, else 0). BRANCH → pcWrite=1, pcSel=brTaken?1:0, go FETCH. FENCE → pcWrite=1, pcSel=0, go FETCH. LOAD/STORE → MEM. Others → WB.
- MEM: dmemReq=1, dmemWe=(STORE). dmemValid=1: LOAD → WB; STORE → pcWrite=1, pcSel=0, go FETCH.
- WB: regWrite=1 unless instr[11:7]=0. wbSel: LOAD=1, JAL/JALR=2, else 0. pcWrite=1, pcSel: JAL=1, JALR=2, else 0. Go FETCH.
- FAULT: all enables and requests 0, fault=1; leaves only by reset.
- Outputs not listed for a state are 0; control outputs are a function of state and instr only (Moore + IR).
- Wait counter: reset to 0 on every state entry; in FETCH/MEM with no valid, if counter=TIMEOUT-1 go FAULT, else increment. Valid in the limit cycle wins (normal transition).

## Timing
- Reset (rstn=0 at clock edge): state=FETCH, instr=0x00000013, counter=0, fault=0; while rstn=0 all outputs forced 0. First imemReq the cycle after rstn samples 1.
- Reset mid-operation (any state, incl. MEM with dmemReq high) aborts immediately; no pcWrite/regWrite that cycle.
- Request held continuously until valid; valid without request ignored; req drops the cycle after valid.
- Latency with zero-wait memories (valid same cycle as req): ALU/LUI/AUIPC/JAL/JALR 4 cycles, LOAD 5, STORE 4, BRANCH/FENCE 3; each memory wait cycle adds 1.
- pcWrite and regWrite occur in the same cycle (WB) so rd gets pc+4 of the old PC for JAL/JALR.

## Test plan
- instr 0x00500093 (addi x1,x0,5), zero-wait → states 0,1,2,4,0; regWrite=1, wbSel=0, aluSrcB=1, pcWrite/pcSel=0 in WB only.
- Load 0x0000a103, dmemValid after 3 wait cycles → dmemReq high 4 cycles, dmemWe=0, then WB with wbSel=1; total 8 cycles.
- beq with brTaken=1 then brTaken=0 → EXEC pcWrite=1, pcSel=1 then 0; no regWrite, 3 cycles each.
- instr 0xFFFFFFFF → FETCH, DECODE, FAULT; fault=1 stays with all enables 0 until rstn low, then state=0, fault=0.
- imemValid never asserted, TIMEOUT=16 → FAULT after exactly 16 FETCH cycles; repeat with valid on 16th cycle → DECODE, no fault.
- Store 0x00112023 with rstn pulled low during second MEM wait cycle → next cycle state=0, no pcWrite, instr=0x00000013.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with instruction register.
// Ports: clk/rstn (sync active-low); imemReq/imemValid/imemData fetch handshake; instr IR out;
// brTaken branch result; dmemReq/dmemWe/dmemValid data handshake; pcWrite/pcSel PC control;
// regWrite/wbSel register write-back; aluSrcA/aluSrcB operand muxes; state debug; fault flag.
module instr_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imemReq,
    input  logic        imemValid,
    input  logic [31:0] imemData,
    output logic [31:0] instr,
    input  logic        brTaken,
    output logic        dmemReq,
    output logic        dmemWe,
    input  logic        dmemValid,
    output logic        pcWrite,
    output logic [1:0]  pcSel,
    output logic        regWrite,
    output logic [1:0]  wbSel,
    output logic        aluSrcA,
    output logic        aluSrcB,
    output logic [2:0]  state,
    output logic        fault
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;
    localparam int CW = $clog2(TIMEOUT);

    logic [2:0]    next_state;
    logic [CW-1:0] cnt;
    logic          tmo;
    logic          c_r, c_i, c_ld, c_st, c_br, c_lui, c_auipc, c_jal, c_jalr, c_fence, legal;
    logic          in_ex, in_wb;

    assign c_r     = instr[6:0] == 7'b0110011;
    assign c_i     = instr[6:0] == 7'b0010011;
    assign c_ld    = instr[6:0] == 7'b0000011;
    assign c_st    = instr[6:0] == 7'b0100011;
    assign c_br    = instr[6:0] == 7'b1100011;
    assign c_lui   = instr[6:0] == 7'b0110111;
    assign c_auipc = instr[6:0] == 7'b0010111;
    assign c_jal   = instr[6:0] == 7'b1101111;
    assign c_jalr  = instr[6:0] == 7'b1100111;
    assign c_fence = instr[6:0] == 7'b0001111;
    assign legal   = c_r | c_i | c_ld | c_st | c_br | c_lui | c_auipc | c_jal | c_jalr | c_fence;
    assign tmo     = cnt == CW'(TIMEOUT - 1);

    always_comb begin
        next_state = S_FAULT;
        case (state)
            S_FETCH:  next_state = imemValid ? S_DECODE : (tmo ? S_FAULT : S_FETCH);
            S_DECODE: next_state = legal ? S_EXEC : S_FAULT;
            S_EXEC:   next_state = (c_br | c_fence) ? S_FETCH : ((c_ld | c_st) ? S_MEM : S_WB);
            S_MEM:    next_state = dmemValid ? (c_ld ? S_WB : S_FETCH) : (tmo ? S_FAULT : S_MEM);
            S_WB:     next_state = S_FETCH;
            default:  next_state = S_FAULT;
        endcase
    end

    // Every control output is masked while rstn is low so a reset aborts the cycle cleanly.
    always_comb begin
        in_ex    = rstn && state == S_EXEC;
        in_wb    = rstn && state == S_WB;
        imemReq  = rstn && state == S_FETCH;
        dmemReq  = rstn && state == S_MEM;
        dmemWe   = dmemReq && c_st;
        aluSrcA  = in_ex && (c_auipc | c_jal);
        aluSrcB  = in_ex && !(c_r | c_br);
        pcWrite  = (in_ex && (c_br | c_fence)) || (dmemWe && dmemValid) || in_wb;
        pcSel    = (in_ex && c_br && brTaken) || (in_wb && c_jal) ? 2'd1 : (in_wb && c_jalr ? 2'd2 : 2'd0);
        regWrite = in_wb && instr[11:7] != 5'd0;
        wbSel    = in_wb ? (c_ld ? 2'd1 : ((c_jal | c_jalr) ? 2'd2 : 2'd0)) : 2'd0;
        fault    = rstn && state == S_FAULT;
    end

    // The wait counter runs only while FETCH/MEM stall; any state change clears it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_FETCH;
            instr <= 32'h0000_0013;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == S_FETCH && imemValid) instr <= imemData;
            cnt <= (next_state == state && (state == S_FETCH || state == S_MEM)) ? cnt + 1'b1 : '0;
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed self-checking bench for instr_sequencer.
module tb_instr_sequencer;
    logic        clk = 1'b0, rstn = 1'b0;
    logic        imemValid = 1'b0, brTaken = 1'b0, dmemValid = 1'b0;
    logic [31:0] imemData = '0;
    logic        imemReq, dmemReq, dmemWe, pcWrite, regWrite, aluSrcA, aluSrcB, fault;
    logic [1:0]  pcSel, wbSel;
    logic [2:0]  state;
    logic [31:0] instr;
    logic [11:0] ctl;
    int          checks = 0, errors = 0;

    instr_sequencer #(.TIMEOUT(16)) dut (
        .clk(clk), .rstn(rstn), .imemReq(imemReq), .imemValid(imemValid), .imemData(imemData),
        .instr(instr), .brTaken(brTaken), .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemValid(dmemValid),
        .pcWrite(pcWrite), .pcSel(pcSel), .regWrite(regWrite), .wbSel(wbSel),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .state(state), .fault(fault)
    );

    // {imemReq,dmemReq,dmemWe,pcWrite,pcSel[1:0],regWrite,wbSel[1:0],aluSrcA,aluSrcB,fault}
    assign ctl = {imemReq, dmemReq, dmemWe, pcWrite, pcSel, regWrite, wbSel, aluSrcA, aluSrcB, fault};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        cyc;
        cyc;
        rstn = 1'b1;
        #1;
    endtask

    task automatic fetch(input logic [31:0] d);
        check("fetch_state", state, 0);
        check("fetch_ctl", ctl, 12'b1_0_0_0_00_0_00_0_0_0);
        imemValid = 1'b1;
        imemData  = d;
        cyc;
        imemValid = 1'b0;
        imemData  = 32'hdead_beef;
        check("decode_state", state, 1);
        check("ir", instr, d);
        check("decode_ctl", ctl, 12'b0);
    endtask

    initial begin
        // reset
        rstn = 1'b0;
        #1;
        check("rst_ctl_forced", ctl, 12'b0);
        cyc;
        check("rst_state", state, 0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_ctl", ctl, 12'b0);
        rstn = 1'b1;
        #1;
        check("first_req", imemReq, 1);

        // addi x1,x0,5
        fetch(32'h0050_0093);
        cyc; check("addi_exec", state, 2); check("addi_exec_ctl", ctl, 12'b0_0_0_0_00_0_00_0_1_0);
        cyc; check("addi_wb", state, 4);   check("addi_wb_ctl", ctl, 12'b0_0_0_1_00_1_00_0_0_0);
        cyc; check("addi_done", state, 0);

        // lw x2,0(x1) with three data wait cycles
        fetch(32'h0000_a103);
        cyc; check("lw_exec_ctl", ctl, 12'b0_0_0_0_00_0_00_0_1_0);
        cyc; check("lw_mem", state, 3); check("lw_mem_ctl", ctl, 12'b0_1_0_0_00_0_00_0_0_0);
        for (int i = 0; i < 3; i++) begin
            cyc; check("lw_mem_wait", ctl, 12'b0_1_0_0_00_0_00_0_0_0);
        end
        dmemValid = 1'b1;
        cyc;
        dmemValid = 1'b0;
        check("lw_wb", state, 4); check("lw_wb_ctl", ctl, 12'b0_0_0_1_00_1_01_0_0_0);
        cyc; check("lw_done", state, 0);

        // beq taken, then not taken
        fetch(32'h0000_0063);
        brTaken = 1'b1;
        cyc; check("beq_t_exec", ctl, 12'b0_0_0_1_01_0_00_0_0_0);
        cyc; check("beq_t_done", state, 0);
        fetch(32'h0000_0063);
        brTaken = 1'b0;
        cyc; check("beq_n_exec", ctl, 12'b0_0_0_1_00_0_00_0_0_0);
        cyc; check("beq_n_done", state, 0);

        // jal x1,8 and jalr x1,0(x1)
        fetch(32'h0080_00ef);
        cyc; check("jal_exec", ctl, 12'b0_0_0_0_00_0_00_1_1_0);
        cyc; check("jal_wb", ctl, 12'b0_0_0_1_01_1_10_0_0_0);
        cyc;
        fetch(32'h0000_80e7);
        cyc; check("jalr_exec", ctl, 12'b0_0_0_0_00_0_00_0_1_0);
        cyc; check("jalr_wb", ctl, 12'b0_0_0_1_10_1_10_0_0_0);
        cyc;

        // nop writes rd=x0: no regWrite
        fetch(32'h0000_0013);
        cyc;
        cyc; check("nop_wb", ctl, 12'b0_0_0_1_00_0_00_0_0_0);
        cyc;

        // zero-wait store
        fetch(32'h0011_2023);
        cyc;
        cyc; check("sw_mem", ctl, 12'b0_1_1_0_00_0_00_0_0_0);
        dmemValid = 1'b1;
        #1;
        check("sw_mem_valid", ctl, 12'b0_1_1_1_00_0_00_0_0_0);
        cyc;
        dmemValid = 1'b0;
        check("sw_done", state, 0);

        // illegal instruction
        fetch(32'hffff_ffff);
        cyc; check("ill_state", state, 5); check("ill_ctl", ctl, 12'b0_0_0_0_00_0_00_0_0_1);
        imemValid = 1'b1;
        cyc; cyc;
        imemValid = 1'b0;
        check("ill_sticky", state, 5); check("ill_sticky_ctl", ctl, 12'b0_0_0_0_00_0_00_0_0_1);
        rstn = 1'b0;
        #1;
        check("ill_rst_fault", fault, 0);
        cyc;
        rstn = 1'b1;
        #1;
        check("ill_rst_state", state, 0);

        // fetch timeout: 16 FETCH cycles then FAULT
        for (int i = 0; i < 15; i++) begin
            cyc; check("tmo_wait", state, 0);
        end
        cyc; check("tmo_fault", state, 5); check("tmo_fault_flag", fault, 1);
        do_reset;
        for (int i = 0; i < 15; i++) cyc;
        imemValid = 1'b1;
        imemData  = 32'h0050_0093;
        cyc;
        imemValid = 1'b0;
        check("tmo_limit_valid", state, 1); check("tmo_limit_fault", fault, 0);
        cyc; cyc; cyc;
        check("tmo_limit_done", state, 0);

        // reset during second MEM wait cycle of a store
        fetch(32'h0011_2023);
        cyc;
        cyc;
        cyc; check("sw_wait2", ctl, 12'b0_1_1_0_00_0_00_0_0_0);
        rstn = 1'b0;
        #1;
        check("sw_rst_ctl", ctl, 12'b0);
        cyc;
        check("sw_rst_state", state, 0);
        check("sw_rst_instr", instr, 32'h0000_0013);
        check("sw_rst_pcw", pcWrite, 0);
        rstn = 1'b1;
        #1;
        check("sw_rst_req", imemReq, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
